ct_mmu_jtlb_tag_arb: RTL

- Arbiter and sequencer in front of the JTLB tag array; the tag array is a single-port 256-entry SRAM with 1-cycle read latency.
- Shares the array between three requesters:
  - lookup reads from the page-walk/lookup path;
  - refill writes from the PTW;
  - an invalidate-all sweep FSM that zeroes every index.
- Drives the tag array's cen/idx/wen/din and returns read data with a valid strobe.

---
 rtl/ct_mmu_jtlb_pkg.sv | 14 +
 rtl/ct_mmu_jtlb_inv_sweep.sv | 59 +++++
 rtl/ct_mmu_jtlb_tag_arb.sv | 109 ++++++++++
 3 files changed

// File: rtl/ct_mmu_jtlb_pkg.sv
// Shared sizes and FSM state encoding for the JTLB tag-array arbiter.
package ct_mmu_jtlb_pkg;
    localparam int JTLB_IDX_W  = 8;
    localparam int JTLB_WAY_N  = 5;
    localparam int JTLB_WAY_W  = 48;
    localparam int JTLB_FIFO_W = 4;
    localparam int JTLB_DATA_W = (JTLB_WAY_N - 1) * JTLB_WAY_W + JTLB_FIFO_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } jtlb_arb_state_e;
endpackage

// File: rtl/ct_mmu_jtlb_inv_sweep.sv
// Invalidate-all sequencer: walks every tag index once, then pulses done.
module ct_mmu_jtlb_inv_sweep
    import ct_mmu_jtlb_pkg::*;
#(
    parameter int IDX_W = JTLB_IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_b_i,
    input  logic             req_i,
    output logic             start_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [IDX_W-1:0] idx_o
);

    jtlb_arb_state_e  state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    start_o = 1'b1;
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                busy_o = 1'b1;
                cnt_d  = cnt_q + IDX_W'(1);
                // Last index written this cycle; the wrap back to 0 is harmless.
                if (&cnt_q) state_d = DONE;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign idx_o = cnt_q;

endmodule

// File: rtl/ct_mmu_jtlb_tag_arb.sv
// JTLB tag-array port arbiter: lookup reads, PTW refill writes and the
// invalidate-all sweep share one single-port SRAM with 1-cycle read latency.
module ct_mmu_jtlb_tag_arb
    import ct_mmu_jtlb_pkg::*;
#(
    parameter int IDX_W        = JTLB_IDX_W,
    parameter int DATA_W       = JTLB_DATA_W,
    parameter int WAY_N        = JTLB_WAY_N,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst_b,
    input  logic              rd_req,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_gnt,
    output logic              rd_dout_vld,
    output logic [DATA_W-1:0] rd_dout,
    input  logic              wr_req,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WAY_N-1:0]  wr_way_en,
    input  logic [DATA_W-1:0] wr_din,
    output logic              wr_gnt,
    input  logic              inv_all_req,
    output logic              inv_all_busy,
    output logic              inv_all_done,
    output logic              jtlb_tag_cen,
    output logic [IDX_W-1:0]  jtlb_tag_idx,
    output logic [WAY_N-1:0]  jtlb_tag_wen,
    output logic [DATA_W-1:0] jtlb_tag_din,
    input  logic [DATA_W-1:0] jtlb_tag_dout
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

    logic             sw_start, sw_busy, sw_done;
    logic [IDX_W-1:0] sw_idx;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic             rd_vld_q;
    logic             rd_win;

    ct_mmu_jtlb_inv_sweep #(.IDX_W(IDX_W)) u_sweep (
        .clk_i   (forever_cpuclk),
        .rst_b_i (cpurst_b),
        .req_i   (inv_all_req),
        .start_o (sw_start),
        .busy_o  (sw_busy),
        .done_o  (sw_done),
        .idx_o   (sw_idx)
    );

    // Write normally wins; a read that has lost STARVE_LIMIT conflicts in a row wins the next one.
    assign rd_win = rd_req & (~wr_req | (starve_q == SC_MAX));

    always_comb begin
        rd_gnt       = 1'b0;
        wr_gnt       = 1'b0;
        jtlb_tag_cen = 1'b0;
        jtlb_tag_idx = '0;
        jtlb_tag_wen = '0;
        jtlb_tag_din = '0;
        if (cpurst_b) begin
            if (sw_busy) begin
                jtlb_tag_cen = 1'b1;
                jtlb_tag_idx = sw_idx;
                jtlb_tag_wen = '1;
            end else if (!sw_start) begin
                if (rd_win) begin
                    rd_gnt       = 1'b1;
                    jtlb_tag_cen = 1'b1;
                    jtlb_tag_idx = rd_idx;
                end else if (wr_req) begin
                    wr_gnt = 1'b1;
                    // An all-zero enable write is acknowledged but never reaches the array.
                    if (|wr_way_en) begin
                        jtlb_tag_cen = 1'b1;
                        jtlb_tag_idx = wr_idx;
                        jtlb_tag_wen = wr_way_en;
                        jtlb_tag_din = wr_din;
                    end
                end
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!rd_req || rd_gnt)
            starve_d = '0;
        else if (wr_req && wr_gnt && (starve_q != SC_MAX))
            starve_d = starve_q + SC_W'(1);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            starve_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rd_vld_q <= rd_gnt;
        end
    end

    assign rd_dout_vld  = rd_vld_q;
    assign rd_dout      = jtlb_tag_dout;
    assign inv_all_busy = cpurst_b & sw_busy;
    assign inv_all_done = cpurst_b & sw_done;

endmodule
